// File: rtl/rx_frame_arbiter_if.sv
// Bundle between the per-port RX FIFOs, the frame arbiter and the downstream
// L2 lookup stage, plus the gray-coded monitor counters.
interface rx_frame_arbiter_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned PW     = 2
);
  logic [NPORTS-1:0]   port_en;
  logic [NPORTS-1:0]   fifo_empty;
  logic [8*NPORTS-1:0] fifo_dout;
  logic [NPORTS-1:0]   fifo_EOD_out;
  logic [NPORTS-1:0]   fifo_rden;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_last;
  logic [PW-1:0]       out_port;
  logic                out_ready;
  logic [15:0]         frames_fwd_gray;
  logic [15:0]         trunc_count_gray;

  modport master (
    input  port_en, fifo_empty, fifo_dout, fifo_EOD_out, out_ready,
    output fifo_rden, out_data, out_valid, out_last, out_port,
           frames_fwd_gray, trunc_count_gray
  );

  modport slave (
    output port_en, fifo_empty, fifo_dout, fifo_EOD_out, out_ready,
    input  fifo_rden, out_data, out_valid, out_last, out_port,
           frames_fwd_gray, trunc_count_gray
  );
endinterface

// File: rtl/rx_frame_arbiter.sv
// Frame-granular round-robin arbiter: forwards one whole frame per grant from
// one of NPORTS FWFT RX FIFOs, truncates at MAX_FRAME and counts frames in gray.
module rx_frame_arbiter #(
  parameter int unsigned NPORTS    = 4,
  parameter int unsigned PW        = 2,
  parameter int unsigned MAX_FRAME = 1522
) (
  input  logic               REF_CLK,
  input  logic               arst_n,
  rx_frame_arbiter_if.master bus
);
  localparam int unsigned CW = 11;
  localparam int unsigned GW = 16;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q;
  logic [PW-1:0] last_grant_q;
  logic [PW-1:0] out_port_q;
  logic [CW-1:0] byte_cnt_q;
  logic [GW-1:0] frames_q;
  logic [GW-1:0] trunc_q;
  logic [GW-1:0] frames_gray_q;
  logic [GW-1:0] trunc_gray_q;

  logic [NPORTS-1:0]   req;
  logic [NPORTS-1:0]   req_sh;
  logic [NPORTS-1:0]   empty_sh;
  logic [NPORTS-1:0]   eod_sh;
  logic [8*NPORTS-1:0] dout_sh;
  int unsigned         idx;
  logic                req_any;
  logic [PW-1:0]       grant_d;
  logic                head_empty;
  logic                head_eod;
  logic                pop;

  assign req = ~bus.fifo_empty & bus.port_en;

  // Round-robin search starting just after the previous grant, with wrap.
  always_comb begin
    grant_d = last_grant_q;
    req_any = 1'b0;
    idx     = 0;
    req_sh  = '0;
    for (int unsigned k = 1; k <= NPORTS; k++) begin
      idx = 32'(last_grant_q) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      req_sh = req >> idx;
      if (!req_any && req_sh[0]) begin
        req_any = 1'b1;
        grant_d = PW'(idx);
      end
    end
  end

  // Head of the granted FIFO; shifts keep the select width-independent of PW.
  assign empty_sh   = bus.fifo_empty >> out_port_q;
  assign eod_sh     = bus.fifo_EOD_out >> out_port_q;
  assign dout_sh    = bus.fifo_dout >> {out_port_q, 3'b000};
  assign head_empty = empty_sh[0];
  assign head_eod   = eod_sh[0];

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.fifo_rden = '0;
    pop           = 1'b0;
    case (state_q)
      S_XFER: begin
        bus.out_valid = ~head_empty;
        bus.out_last  = head_eod | (byte_cnt_q == LAST_CNT);
        pop           = ~head_empty & bus.out_ready;
      end
      S_DRAIN: pop = ~head_empty;
      default: pop = 1'b0;
    endcase
    if (pop) bus.fifo_rden = NPORTS'(1) << out_port_q;
  end

  assign bus.out_data         = dout_sh[7:0];
  assign bus.out_port         = out_port_q;
  assign bus.frames_fwd_gray  = frames_gray_q;
  assign bus.trunc_count_gray = trunc_gray_q;

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= PW'(NPORTS - 1);
      out_port_q    <= '0;
      byte_cnt_q    <= '0;
      frames_q      <= '0;
      trunc_q       <= '0;
      frames_gray_q <= '0;
      trunc_gray_q  <= '0;
    end else begin
      frames_gray_q <= frames_q ^ (frames_q >> 1);
      trunc_gray_q  <= trunc_q ^ (trunc_q >> 1);
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            out_port_q   <= grant_d;
            last_grant_q <= grant_d;
            byte_cnt_q   <= '0;
            state_q      <= S_XFER;
          end
        end
        S_XFER: begin
          if (pop) begin
            byte_cnt_q <= byte_cnt_q + CW'(1);
            // EOD wins over truncation when both land on the same byte
            if (head_eod) begin
              frames_q <= frames_q + GW'(1);
              state_q  <= S_IDLE;
            end else if (byte_cnt_q == LAST_CNT) begin
              trunc_q <= trunc_q + GW'(1);
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && head_eod) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/rx_frame_arbiter.md
# rx_frame_arbiter

- Frame-granular round-robin arbiter that shares one downstream byte stream between NPORTS receive FIFOs, each filled by an RMII receiver.
- Sits between the per-port RX FIFOs and the L2 switch lookup/forwarding stage.
- Grants one port at a time and forwards exactly one frame, delimited by the FIFO end-of-data flag, before re-arbitrating.
- Also enforces a maximum frame length and keeps gray-coded monitor counters.

## Interface
Parameters:
- NPORTS, 4 — number of RX FIFOs arbitrated (2..8).
- PW, 2 — port index width, ≥ clog2(NPORTS).
- MAX_FRAME, 1522 — maximum bytes forwarded per frame (≤ 2047).

Ports:
- REF_CLK  in  1  single clock; all logic on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- port_en  in  NPORTS  per-port grant enable; a disabled port is never newly granted.
- fifo_empty  in  NPORTS  per-port empty flag (FWFT FIFOs).
- fifo_dout  in  8*NPORTS  per-port head byte; port i uses bits [8i+7:8i].
- fifo_EOD_out  in  NPORTS  head byte is the last byte of its frame.
- fifo_rden  out  NPORTS  pop strobe; at most one bit high per cycle.
- out_data  out  8  forwarded byte.
- out_valid  out  1  out_data is valid.
- out_last  out  1  final byte of the forwarded frame.
- out_port  out  PW  index of the granted port, stable for the whole frame.
- out_ready  in  1  downstream accepts the byte this cycle.
- frames_fwd_gray  out  16  frames forwarded, gray-coded.
- trunc_count_gray  out  16  frames truncated at MAX_FRAME, gray-coded.

## Operation
- States: S_IDLE, S_XFER, S_DRAIN.
- S_IDLE:
  - A request is `req[i] = ~fifo_empty[i] & port_en[i]`.
  - If any request is present, grant the first requesting port searching from (last_grant+1) mod NPORTS upward with wrap.
  - Register the grant into out_port and last_grant, clear byte_cnt, and go to S_XFER.
  - No pops occur in S_IDLE.
- S_XFER:
  - out_valid = ~fifo_empty[g].
  - out_data = fifo_dout[g].
  - out_last = fifo_EOD_out[g] | (byte_cnt == MAX_FRAME-1).
  - fifo_rden[g] = out_valid & out_ready. A byte counts as accepted when it is popped.
  - Each accepted byte increments byte_cnt (11 bits).
  - Accepted byte with fifo_EOD_out[g]=1: frames_fwd++, go to S_IDLE.
  - Accepted byte with byte_cnt == MAX_FRAME-1 and EOD=0: trunc_count++, go to S_DRAIN. The downstream sees out_last on that byte.
  - If the FIFO goes empty mid-frame, hold in S_XFER with out_valid=0. The grant is kept; there is no timeout.
  - Deasserting port_en[g] mid-frame has no effect until the frame ends.
- S_DRAIN:
  - fifo_rden[g] = ~fifo_empty[g], independent of out_ready.
  - out_valid = 0.
  - The pop of a byte with EOD=1 goes to S_IDLE. That byte is discarded.
- Counters:
  - 16-bit binary, wrapping 0xFFFF→0x0000.
  - Outputs are registered gray conversions, (b >> 1) ^ b, updated the cycle after the binary change.
- Undefined state encoding: go to S_IDLE with no pops.
- Reset values:
  - State S_IDLE, last_grant = NPORTS-1 (so port 0 wins first), out_port = 0, byte_cnt = 0.
  - Counters 0, gray outputs 0.
  - fifo_rden = 0, out_valid = 0, out_last = 0.
  - out_data follows fifo_dout[out_port] but is don't-care while invalid.
- Reset mid-frame: drop the grant immediately with no further pops. The partial frame remains in the FIFO.

## Timing
- Arbitration latency is 1 cycle: a request seen in S_IDLE at edge t gives out_valid at cycle t+1.
- out_data, out_valid, out_last and fifo_rden are combinational from the registered grant/state and the FIFO outputs. There is no pipeline register.
- Throughput is 1 byte/cycle while out_ready=1 and the FIFO is non-empty.
- Per-frame overhead is 1 idle cycle between frames, even for back-to-back frames on the same port.
- Round-robin is fair: with all ports requesting continuously, grants rotate 0,1,2,3,0…
- A single requesting port is re-granted after its 1-cycle idle.

## Test plan
- **Single frame:** port 2 holds 64 bytes 0x00..0x3F, EOD on 0x3F, out_ready=1 → out_port=2, 64 consecutive valid beats, out_last only on 0x3F, frames_fwd_gray=0x0001.
- **Rotation:** all 4 ports each hold two 60-byte frames → grant order 0,1,2,3,0,1,2,3, with one idle cycle between frames; frames_fwd=8 (gray 0x000C).
- **Backpressure:** toggle out_ready every cycle during a 100-byte frame → each byte is delivered exactly once, in order, and fifo_rden is never high while out_ready=0.
- **Oversize:** port 1 holds a 1600-byte frame → 1522 bytes forwarded with out_last on byte 1522, the remaining 78 bytes popped with out_valid=0, trunc_count_gray=0x0001, then return to S_IDLE.
- **Masking and starvation:** port_en=4'b1101 with all ports requesting → port 1 is never granted. fifo_empty[0] asserted for 5 cycles mid-frame → out_valid=0 for 5 cycles, grant held.
- **Reset mid-frame:** pull arst_n low during byte 10 → fifo_rden=0 and out_valid=0 immediately; after release, port 0 is granted first.
